// File: rtl/brc_seq.sv
// brc_seq: multi-cycle branch comparator.
//
// Compares operand A (rs1) against operand B (rs2, or the extended immediate
// when i_slti_sel = 1) MSB-first, CHUNK_W bits per clock. Signed compares are
// turned into unsigned ones by flipping the sign bit of both operands at accept
// time.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_valid / o_ready       request handshake (o_ready high only in idle)
//   i_rs1_data, i_rs2_data  operands A and B
//   i_imm, i_slti_sel       immediate and B-select (1: B = i_imm)
//   i_br_un                 1: unsigned compare, 0: signed compare
//   i_funct3                branch type used for o_taken
//   o_valid / i_ready       result handshake; results held while i_ready = 0
//   o_br_less, o_br_equal   A < B, A == B (registered, 0 when o_valid = 0)
//   o_taken                 funct3-decoded branch-taken flag
//
// Optional feature macro: BRC_SEQ_EARLY_EXIT_EN
//   Defined: finish as soon as the first differing chunk is found.
//   Undefined: always NCHUNK compare cycles.

module brc_seq #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CHUNK_W = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_slti_sel,
  input  logic            i_br_un,
  input  logic [2:0]      i_funct3,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_br_less,
  output logic            o_br_equal,
  output logic            o_taken
);

  localparam int unsigned NCHUNK = XLEN / CHUNK_W;
  localparam int unsigned CntW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NCHUNK - 1);

  if ((CHUNK_W == 0) || (XLEN % CHUNK_W != 0)) begin : g_bad_chunk
    $error("brc_seq: CHUNK_W must divide XLEN");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              diff_q, diff_d;
  logic              less_q, less_d;
  logic              valid_q, valid_d;
  logic              br_less_q, br_less_d;
  logic              br_equal_q, br_equal_d;
  logic              taken_q, taken_d;

  // Operands shift left one chunk per cycle, so the chunk under compare is
  // always the top CHUNK_W bits.
  logic [CHUNK_W-1:0] chunk_a, chunk_b;
  logic               hit, diff_nxt, less_nxt, done_now;

  assign chunk_a  = a_q[XLEN-1 -: CHUNK_W];
  assign chunk_b  = b_q[XLEN-1 -: CHUNK_W];
  assign hit      = ~diff_q & (chunk_a != chunk_b);
  assign diff_nxt = diff_q | hit;
  assign less_nxt = hit ? (chunk_a < chunk_b) : less_q;

`ifdef BRC_SEQ_EARLY_EXIT_EN
  assign done_now = (cnt_q == LastCnt) | hit;
`else
  assign done_now = (cnt_q == LastCnt);
`endif

  function automatic logic taken_decode(input logic [2:0] f3, input logic eq,
                                        input logic lt);
    case (f3)
      3'b000:         taken_decode = eq;
      3'b001:         taken_decode = ~eq;
      3'b100, 3'b110: taken_decode = lt;
      3'b101, 3'b111: taken_decode = ~lt;
      default:        taken_decode = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    funct3_d   = funct3_q;
    cnt_d      = cnt_q;
    diff_d     = diff_q;
    less_d     = less_q;
    valid_d    = valid_q;
    br_less_d  = br_less_q;
    br_equal_d = br_equal_q;
    taken_d    = taken_q;

    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          a_d      = i_rs1_data;
          b_d      = i_slti_sel ? i_imm : i_rs2_data;
          // Flipping both sign bits maps signed order onto unsigned order.
          if (!i_br_un) begin
            a_d[XLEN-1] = ~i_rs1_data[XLEN-1];
            b_d[XLEN-1] = ~b_d[XLEN-1];
          end
          funct3_d = i_funct3;
          cnt_d    = '0;
          diff_d   = 1'b0;
          less_d   = 1'b0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        a_d    = a_q << CHUNK_W;
        b_d    = b_q << CHUNK_W;
        diff_d = diff_nxt;
        less_d = less_nxt;
        if (done_now) begin
          state_d    = StDone;
          valid_d    = 1'b1;
          br_equal_d = ~diff_nxt;
          br_less_d  = diff_nxt & less_nxt;
          taken_d    = taken_decode(funct3_q, ~diff_nxt, diff_nxt & less_nxt);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (i_ready) begin
          state_d    = StIdle;
          valid_d    = 1'b0;
          br_less_d  = 1'b0;
          br_equal_d = 1'b0;
          taken_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      funct3_q   <= '0;
      cnt_q      <= '0;
      diff_q     <= 1'b0;
      less_q     <= 1'b0;
      valid_q    <= 1'b0;
      br_less_q  <= 1'b0;
      br_equal_q <= 1'b0;
      taken_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      funct3_q   <= funct3_d;
      cnt_q      <= cnt_d;
      diff_q     <= diff_d;
      less_q     <= less_d;
      valid_q    <= valid_d;
      br_less_q  <= br_less_d;
      br_equal_q <= br_equal_d;
      taken_q    <= taken_d;
    end
  end

  assign o_ready    = (state_q == StIdle);
  assign o_valid    = valid_q;
  assign o_br_less  = br_less_q;
  assign o_br_equal = br_equal_q;
  assign o_taken    = taken_q;

endmodule

// File: doc/brc_seq.md
Name: brc_seq

Overview:
- Parametrised, multi-cycle successor of the single-cycle branch comparator.
- Compares rs1 against rs2 (or against the extended immediate for SLTI/SLTIU) MSB-first, CHUNK_W bits per clock.
- Produces less, equal and a funct3-decoded branch-taken flag behind a valid/ready handshake.
- Sits in EX: trades latency for a shorter compare path at large XLEN.

Parameters:
- XLEN, 32, operand width in bits.
- CHUNK_W, 8, bits compared per cycle; must divide XLEN (elaboration error otherwise). NCHUNK = XLEN/CHUNK_W; CHUNK_W == XLEN gives one compare cycle.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  request valid.
- o_ready  output  1  unit can accept a request (high only in IDLE).
- i_rs1_data  input  XLEN  operand A.
- i_rs2_data  input  XLEN  operand B.
- i_imm  input  XLEN  extended immediate.
- i_slti_sel  input  1  1: B = i_imm, 0: B = i_rs2_data.
- i_br_un  input  1  1: unsigned compare, 0: signed compare.
- i_funct3  input  3  branch type for o_taken.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts the result.
- o_br_less  output  1  A < B.
- o_br_equal  output  1  A == B.
- o_taken  output  1  branch-taken decode.

Behaviour:
- Reset is asynchronous and active-low: state = IDLE; o_valid, o_br_less, o_br_equal, o_taken = 0; o_ready = 1 once in IDLE.
- Reset asserted mid-operation aborts the operation; no result is produced.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On i_valid & o_ready, latch A and B (B selected by i_slti_sel) and latch i_br_un and i_funct3.
  - If signed, invert bit XLEN-1 of both latched operands; the signed compare then reduces to an unsigned compare.
  - Clear chunk counter cnt, set diff_found = 0, go to BUSY.
  - Inputs are sampled only at the accept edge; later changes have no effect.
- BUSY, each cycle, chunk index k = NCHUNK-1-cnt:
  - If diff_found == 0 and A_k != B_k: diff_found = 1, less = (A_k < B_k) as unsigned.
  - Equal chunks leave state unchanged.
  - When cnt == NCHUNK-1, go to DONE; otherwise cnt++.
- Result: o_br_equal = ~diff_found; o_br_less = diff_found & less.
- Latency: o_valid rises NCHUNK clock edges after the accept edge. Throughput is one operation per NCHUNK+2 cycles minimum.
- DONE:
  - o_valid = 1; o_ready = 0.
  - Outputs are held stable while i_ready = 0.
  - On i_ready = 1: o_valid drops at the next edge and state returns to IDLE.
  - New i_valid is ignored until IDLE.
- o_taken decode from the latched funct3:
  - 000 (BEQ) = equal.
  - 001 (BNE) = ~equal.
  - 100 / 110 (BLT / BLTU) = less.
  - 101 / 111 (BGE / BGEU) = ~less.
  - 010, 011 = 0.
- Signedness always comes from i_br_un, not from funct3; the caller drives i_br_un consistently.
- o_br_less, o_br_equal and o_taken are registered; they are meaningful only while o_valid = 1 and read 0 otherwise.

Optional Feature:
- Macro: BRC_SEQ_EARLY_EXIT_EN.
- Defined: when BUSY finds the first unequal chunk, the FSM goes straight to DONE that cycle. Latency = j+1 edges, where j is the MSB-first index of the first differing chunk. Equal operands still take NCHUNK edges.
- Undefined: fixed NCHUNK-edge latency for all operands.
- Results are identical in both builds.

Test Plan (XLEN=32, CHUNK_W=8, NCHUNK=4):
- Reset and release -> o_valid = 0, all flags 0, o_ready = 1; assert i_rst_n low during BUSY -> IDLE next cycle, no o_valid.
- BEQ: rs1 = rs2 = 0x12345678, funct3 = 000 -> o_valid at edge 4; equal = 1, less = 0, taken = 1. Same latency with the early-exit macro defined.
- BLT: rs1 = 0xFFFFFFFF, rs2 = 0x00000001, br_un = 0, funct3 = 100 -> less = 1, taken = 1.
  - Repeat with br_un = 1, funct3 = 110 -> less = 0, taken = 0.
  - Latency 4 without the macro, 1 with it.
- SLTI: slti_sel = 1, imm = 0x00000010, rs1 = 0x0000000F, rs2 = 0xDEADBEEF -> less = 1, equal = 0, latency 4 in both builds.
- Backpressure: hold i_ready = 0 for 3 cycles in DONE while pulsing i_valid with new operands -> outputs unchanged, o_ready = 0, second request not accepted; i_ready = 1 -> o_valid drops next cycle, o_ready = 1.
- BGE: rs1 = 0x80000000, rs2 = 0x7FFFFFFF, br_un = 0, funct3 = 101 -> less = 1, taken = 0.
  - Repeat with funct3 = 010 -> taken = 0.
